// File: rtl/axi2mem_pkg.sv
// Shared definitions for the AXI4-Lite to byte-wide SRAM bridge.
//   state_t      : bridge FSM state encoding
//   RESP_OKAY    : AXI response code for a completed access
//   RESP_SLVERR  : AXI response code for an access aborted by BIST
//   SRAM_DEPTH   : number of bytes in the attached SRAM
package axi2mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_RD_TAIL,
    ST_WRESP,
    ST_RRESP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int SRAM_DEPTH = 8192;

endpackage

// File: rtl/axil2sram_8.sv
// AXI4-Lite slave that turns 32-bit word accesses into four byte accesses on
// an 8-bit SRAM port (the functional side of a BIST wrapper).
//
// Ports:
//   b_clk, b_rst         : clock, synchronous active-high reset
//   bist_active          : BIST owns the SRAM; block new work, abort in-flight work
//   aw*/w*/b*            : AXI4-Lite write address / data / response channels
//   ar*/r*               : AXI4-Lite read address / data channels
//   sram_addr/wdata      : byte address and byte write data (registered)
//   sram_wen             : 0 = write, 1 = read
//   sram_csn             : active-low chip select (gated combinationally by abort)
//   sram_rdata           : byte read data, valid the cycle after the address
//   busy                 : FSM is not idle
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Readies here are combinational from state and the valids; the
// write path only accepts when awvalid and wvalid are both present, and a
// simultaneous write wins over a read.
module axil2sram_8
  import axi2mem_pkg::*;
#(
  parameter int ADDR_W = 13
) (
  input  logic              b_clk,
  input  logic              b_rst,
  input  logic              bist_active,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  input  logic [ADDR_W-1:0] araddr,
  input  logic              arvalid,
  output logic              arready,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rvalid,
  input  logic              rready,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [7:0]        sram_wdata,
  output logic              sram_wen,
  output logic              sram_csn,
  input  logic [7:0]        sram_rdata,
  output logic              busy
);

  state_t              state_q, state_d;
  logic [1:0]          idx_q;
  logic [1:0]          prev_idx;
  logic [ADDR_W-3:0]   waddr_q;
  logic [31:0]         wdata_q;
  logic [3:0]          wstrb_q;
  logic [31:0]         rdata_q;
  logic [1:0]          resp_q;
  logic                abort;

  // Word alignment discards the two low address bits.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{awaddr[1:0], araddr[1:0]};

  always_ff @(posedge b_clk) begin
    if (b_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    awready  = 1'b0;
    wready   = 1'b0;
    arready  = 1'b0;
    abort    = 1'b0;
    sram_csn = 1'b1;
    sram_wen = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (!bist_active) begin
          if (awvalid && wvalid) begin
            awready = 1'b1;
            wready  = 1'b1;
            state_d = ST_WR;
          end else if (arvalid) begin
            arready = 1'b1;
            state_d = ST_RD;
          end
        end
      end
      ST_WR: begin
        if (bist_active) begin
          abort   = 1'b1;
          state_d = ST_WRESP;
        end else begin
          // Disabled byte lanes still take their cycle, just without a select.
          sram_csn = ~wstrb_q[idx_q];
          sram_wen = 1'b0;
          if (idx_q == 2'd3) state_d = ST_WRESP;
        end
      end
      ST_RD: begin
        if (bist_active) begin
          abort   = 1'b1;
          state_d = ST_RRESP;
        end else begin
          sram_csn = 1'b0;
          if (idx_q == 2'd3) state_d = ST_RD_TAIL;
        end
      end
      ST_RD_TAIL: begin
        abort   = bist_active;
        state_d = ST_RRESP;
      end
      ST_WRESP: if (bready) state_d = ST_IDLE;
      ST_RRESP: if (rready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Byte k-1 is returned by the SRAM while byte k is being addressed.
  assign prev_idx = idx_q - 2'd1;

  always_ff @(posedge b_clk) begin
    if (b_rst) begin
      idx_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      resp_q  <= RESP_OKAY;
    end else if (awready) begin
      waddr_q <= awaddr[ADDR_W-1:2];
      wdata_q <= wdata;
      wstrb_q <= wstrb;
      idx_q   <= '0;
      resp_q  <= RESP_OKAY;
    end else if (arready) begin
      waddr_q <= araddr[ADDR_W-1:2];
      idx_q   <= '0;
      rdata_q <= '0;
      resp_q  <= RESP_OKAY;
    end else if (abort) begin
      rdata_q <= '0;
      resp_q  <= RESP_SLVERR;
    end else begin
      case (state_q)
        ST_WR: idx_q <= idx_q + 2'd1;
        ST_RD: begin
          idx_q <= idx_q + 2'd1;
          if (idx_q != 2'd0) rdata_q[{prev_idx, 3'b000} +: 8] <= sram_rdata;
        end
        ST_RD_TAIL: rdata_q[31:24] <= sram_rdata;
        default: ;
      endcase
    end
  end

  assign sram_addr  = {waddr_q, idx_q};
  assign sram_wdata = wdata_q[{idx_q, 3'b000} +: 8];
  assign rdata      = rdata_q;
  assign bresp      = resp_q;
  assign rresp      = resp_q;
  assign bvalid     = (state_q == ST_WRESP);
  assign rvalid     = (state_q == ST_RRESP);
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: doc/axil2sram_8.md
# axil2sram_8

AXI4-Lite slave that converts 32-bit word transactions into sequences of byte accesses on the 8-bit × 8192 SRAM port. It sits directly upstream of the BIST-wrapped SRAM and drives that wrapper's functional inputs: address, write data, write enable and chip select. It also consumes the wrapper's read data. It yields to BIST: while `bist_active` is high it accepts no new transactions and aborts any in-flight one with SLVERR.

## Interface
- `ADDR_W`, 13: SRAM byte-address width.
- `b_clk` in 1: single clock. All logic is rising-edge.
- `b_rst` in 1: reset, synchronous, active-high.
- `bist_active` in 1: BIST owns the SRAM.
- `awaddr` in ADDR_W, `awvalid` in 1, `awready` out 1: write address channel.
- `wdata` in 32, `wstrb` in 4, `wvalid` in 1, `wready` out 1: write data channel.
- `bresp` out 2, `bvalid` out 1, `bready` in 1: write response channel.
- `araddr` in ADDR_W, `arvalid` in 1, `arready` out 1: read address channel.
- `rdata` out 32, `rresp` out 2, `rvalid` out 1, `rready` in 1: read data channel.
- `sram_addr` out ADDR_W: byte address to the SRAM/BIST wrapper.
- `sram_wdata` out 8: byte write data.
- `sram_wen` out 1: 0 = write, 1 = read.
- `sram_csn` out 1: chip select, active-low.
- `sram_rdata` in 8: read data. Valid in the cycle after the address is presented.
- `busy` out 1: high in any state other than IDLE.

## Operation
- Reset values:
  - `awready`, `wready`, `arready`, `bvalid`, `rvalid`, `busy` = 0.
  - `bresp`, `rresp` = 2'b00.
  - `rdata` = 0.
  - `sram_csn` = 1, `sram_wen` = 1.
  - `sram_addr` = 0, `sram_wdata` = 0.
- States: IDLE, WR, RD, RD_TAIL, WRESP, RRESP.
- Acceptance happens in IDLE only, and only when `bist_active` = 0. The ready signals are combinational.
  - Write: `awready` = `wready` = `awvalid` & `wvalid`. The block waits for both channels and never accepts one alone.
  - Read: `arready` = `arvalid` & ~(`awvalid` & `wvalid`). Writes win simultaneous requests.
- Address handling: the address is word-aligned by forcing bits [1:0] to 0. Byte k (k = 0..3) goes to `{addr[ADDR_W-1:2], k[1:0]}`. Byte order is little-endian: byte k = `wdata[8k+7:8k]`.
- WR state runs a 2-bit byte index k = 0..3, one byte per cycle, always 4 cycles.
  - If `wstrb[k]` = 1: `sram_csn` = 0, `sram_wen` = 0.
  - If `wstrb[k]` = 0: `sram_csn` = 1. The cycle is still consumed.
  - After k = 3 → WRESP.
- RD state issues bytes k = 0..3 with `sram_csn` = 0, `sram_wen` = 1.
  - `sram_rdata` is captured into `rdata[8(k)+7:8(k)]` one cycle after byte k is issued.
  - RD_TAIL captures byte 3 with `sram_csn` = 1, then → RRESP.
- WRESP holds `bvalid` = 1 until `bready`, then → IDLE.
- RRESP holds `rvalid` = 1 and holds `rdata` stable until `rready`, then → IDLE.
- BIST abort: if `bist_active` = 1 in WR, RD or RD_TAIL:
  - `sram_csn` is forced to 1 in that same cycle (combinational gate).
  - No further bytes are issued.
  - The FSM goes to WRESP/RRESP with resp = SLVERR (2'b10); `rdata` = 0 for reads.
  - Bytes already written stay written.
- Reset mid-transaction returns to IDLE. No response is issued.

## Timing
- T = cycle in which the address handshake completes.
- Write:
  - Bytes are on the SRAM port in T+1..T+4.
  - `bvalid` first high in T+5.
  - Best-case throughput: 1 write per 6 cycles.
- Read:
  - Byte addresses are presented in T+1..T+4.
  - Captures happen at the ends of T+2..T+5.
  - `rvalid` first high in T+6.
- SRAM outputs are driven from registered state, index and latched address/data. The only combinational term is the BIST-abort gate on `sram_csn`.
- A new handshake is possible in the cycle after the B/R handshake.

## Structure
- Shared package `axi2mem_pkg` holds:
  - State encoding.
  - `RESP_OKAY` = 2'b00, `RESP_SLVERR` = 2'b10.
  - SRAM depth constant 8192.
- Single module; no sub-module. The byte-index counter and capture logic are too small to split out.

## Test plan
- Write 0x12345678 to 0x0004 with `wstrb` = 4'hF → SRAM writes 0x78@4, 0x56@5, 0x34@6, 0x12@7 in T+1..T+4; `bresp` = OKAY in T+5.
- Read 0x0004 after the above, with a behavioural SRAM model (1-cycle latency) → `rdata` = 0x12345678, `rresp` = OKAY, `rvalid` in T+6.
- Write to 0x1FFD with `wstrb` = 4'b0101, `wdata` = 0xAABBCCDD → writes only 0xDD@0x1FFC and 0xBB@0x1FFE; `sram_csn` = 1 at k = 1, 3.
- `awvalid`/`wvalid`/`arvalid` all raised in the same cycle → write accepted first (`arready` = 0); read accepted the cycle after `bready`.
- `bist_active` raised during the RD state at k = 1 → `sram_csn` = 1 that cycle; `rresp` = SLVERR; `rdata` = 0. With `bist_active` held high, `awready`/`arready` stay 0.
- `b_rst` pulsed during the WR state at k = 2 → next cycle all outputs are at reset values; no `bvalid`.
